// File: rtl/eth_buf_pkg.sv
// Shared types and sizing helpers for the width-converting Ethernet frame buffer.
package eth_buf_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SERVE} rd_state_e;
  typedef enum logic {NORMAL, DISCARD} wr_state_e;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int sub_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/asym_buf_ram.sv
// Simple dual-port behavioural RAM, one clock, registered read, no reset.
module asym_buf_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/asym_frame_buffer.sv
// Frame buffer: wide beats in, narrow beats out; frames are readable only once
// committed, and overflowed or aborted frames are discarded atomically.
module asym_frame_buffer
  import eth_buf_pkg::*;
#(
  parameter int WR_WIDTH = 64,
  parameter int RD_WIDTH = 16,
  parameter int DEPTH    = 512,
  localparam int RATIO = WR_WIDTH / RD_WIDTH,
  localparam int SUBW  = sub_w(RATIO),
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [WR_WIDTH-1:0] wr_data_i,
  input  logic                wr_last_i,
  input  logic [SUBW-1:0]     wr_last_sub_i,
  input  logic                wr_drop_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [RD_WIDTH-1:0] rd_data_o,
  output logic                rd_last_o,
  output logic [PW-1:0]       frame_cnt_o,
  output logic [15:0]         drop_cnt_o,
  output logic                ovf_o
);

  localparam int AW = PW - 1;

  typedef struct packed {
    logic [WR_WIDTH-1:0] data;
    logic                last;
    logic [SUBW-1:0]     last_sub;
  } entry_t;

  localparam int EW = $bits(entry_t);

  wr_state_e wr_state, wr_state_nx;
  rd_state_e rd_state, rd_state_nx;

  logic [PW-1:0]   wr_ptr, wr_ptr_nx, cmt_ptr, cmt_ptr_nx, rd_ptr, rd_ptr_nx;
  logic [SUBW-1:0] sub, sub_nx;
  logic            full, readable;
  logic            ram_we, ram_re, commit, drop_ev, ovf_ev, load, rd_eof, last_beat;
  entry_t          wr_entry, hold;
  logic [EW-1:0]   ram_rdata;

  assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign readable = cmt_ptr != rd_ptr;
  assign wr_entry = '{data: wr_data_i, last: wr_last_i, last_sub: wr_last_sub_i};

  asym_buf_ram #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we && !flush_i),
    .waddr_i(wr_ptr[AW-1:0]),
    .wdata_i(wr_entry),
    .re_i   (ram_re),
    .raddr_i(rd_ptr[AW-1:0]),
    .rdata_o(ram_rdata)
  );

  // Write side: a beat seen while full rolls the working pointer back to the
  // last commit and swallows the rest of that frame.
  always_comb begin
    wr_state_nx = wr_state;
    wr_ptr_nx   = wr_ptr;
    cmt_ptr_nx  = cmt_ptr;
    wr_ready_o  = 1'b1;
    ram_we      = 1'b0;
    commit      = 1'b0;
    drop_ev     = 1'b0;
    ovf_ev      = 1'b0;
    unique case (wr_state)
      NORMAL: begin
        wr_ready_o = !full;
        if (wr_valid_i && full) begin
          wr_state_nx = DISCARD;
          wr_ptr_nx   = cmt_ptr;
          drop_ev     = 1'b1;
          ovf_ev      = 1'b1;
        end else if (wr_valid_i) begin
          if (wr_drop_i) begin
            wr_ptr_nx = cmt_ptr;
            drop_ev   = 1'b1;
          end else begin
            ram_we    = 1'b1;
            wr_ptr_nx = wr_ptr + PW'(1);
            if (wr_last_i) begin
              cmt_ptr_nx = wr_ptr + PW'(1);
              commit     = 1'b1;
            end
          end
        end
      end
      DISCARD: begin
        if (wr_valid_i && wr_last_i) wr_state_nx = NORMAL;
      end
      default: wr_state_nx = NORMAL;
    endcase
  end

  always_comb begin
    rd_state_nx = rd_state;
    rd_ptr_nx   = rd_ptr;
    sub_nx      = sub;
    ram_re      = 1'b0;
    load        = 1'b0;
    rd_eof      = 1'b0;
    rd_valid_o  = 1'b0;
    rd_data_o   = '0;
    last_beat   = 1'b0;
    unique case (rd_state)
      IDLE: begin
        if (readable) begin
          ram_re      = 1'b1;
          rd_state_nx = FETCH;
        end
      end
      FETCH: begin
        load        = 1'b1;
        sub_nx      = '0;
        rd_state_nx = SERVE;
      end
      SERVE: begin
        rd_valid_o = 1'b1;
        rd_data_o  = hold.data[int'(sub)*RD_WIDTH +: RD_WIDTH];
        last_beat  = hold.last && (sub == hold.last_sub);
        if (rd_ready_i) begin
          rd_eof = last_beat;
          if (last_beat || sub == SUBW'(RATIO - 1)) begin
            rd_ptr_nx   = rd_ptr + PW'(1);
            rd_state_nx = IDLE;
          end else begin
            sub_nx = sub + SUBW'(1);
          end
        end
      end
      default: rd_state_nx = IDLE;
    endcase
  end

  assign rd_last_o = last_beat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state    <= NORMAL;
      rd_state    <= IDLE;
      wr_ptr      <= '0;
      cmt_ptr     <= '0;
      rd_ptr      <= '0;
      sub         <= '0;
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
      ovf_o       <= 1'b0;
    end else if (flush_i) begin
      wr_state    <= NORMAL;
      rd_state    <= IDLE;
      wr_ptr      <= '0;
      cmt_ptr     <= '0;
      rd_ptr      <= '0;
      sub         <= '0;
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
      ovf_o       <= 1'b0;
    end else begin
      wr_state <= wr_state_nx;
      rd_state <= rd_state_nx;
      wr_ptr   <= wr_ptr_nx;
      cmt_ptr  <= cmt_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      sub      <= sub_nx;
      ovf_o    <= ovf_ev;
      if (commit && !rd_eof) frame_cnt_o <= frame_cnt_o + PW'(1);
      else if (rd_eof && !commit) frame_cnt_o <= frame_cnt_o - PW'(1);
      if (drop_ev && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load) hold <= entry_t'(ram_rdata);
  end

endmodule

// File: tb/tb_asym_frame_buffer.sv
// Directed bench for asym_frame_buffer (64->16, DEPTH=4 to exercise full/wrap).
module tb_asym_frame_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [63:0] wr_data_i = '0;
  logic        wr_last_i = 1'b0;
  logic [1:0]  wr_last_sub_i = '0;
  logic        wr_drop_i = 1'b0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b1;
  logic [15:0] rd_data_o;
  logic        rd_last_o;
  logic [2:0]  frame_cnt_o;
  logic [15:0] drop_cnt_o;
  logic        ovf_o;

  int vectors = 0;
  int miscompares = 0;
  int rand_mode = 0;
  int ovf_seen = 0;

  logic [15:0] got_d[$];
  logic        got_l[$];
  logic [15:0] exp_d[$];
  logic        exp_l[$];

  asym_frame_buffer #(
    .WR_WIDTH(64),
    .RD_WIDTH(16),
    .DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .wr_last_i(wr_last_i), .wr_last_sub_i(wr_last_sub_i), .wr_drop_i(wr_drop_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .rd_last_o(rd_last_o), .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o),
    .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1 rd_ready_i = (rand_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk_i) begin
    if (rd_valid_o && rd_ready_i) begin
      got_d.push_back(rd_data_o);
      got_l.push_back(rd_last_o);
    end
    if (ovf_o) ovf_seen++;
  end

  task automatic wr_beat(input logic [63:0] d, input logic last, input logic [1:0] ls,
                         input logic drop, output int waits);
    wr_valid_i = 1'b1; wr_data_i = d; wr_last_i = last;
    wr_last_sub_i = ls; wr_drop_i = drop;
    waits = 0;
    while (!wr_ready_o && waits < 50) begin
      @(posedge clk_i); #1; waits++;
    end
    if (!wr_ready_o) begin
      vectors++; miscompares++;
      $display("FAIL wr_ready_timeout got=%b need=1", wr_ready_o);
    end
    @(posedge clk_i); #1;
    wr_valid_i = 1'b0; wr_last_i = 1'b0; wr_drop_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((frame_cnt_o != 0 || rd_valid_o) && n < 300) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 300) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout frame_cnt=%0d need=0", frame_cnt_o);
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_rd_valid();
    int n = 0;
    while (!rd_valid_o && n < 50) begin
      @(posedge clk_i); #1; n++;
    end
    if (!rd_valid_o) begin
      vectors++; miscompares++;
      $display("FAIL rd_valid_timeout got=0 need=1");
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    vectors += 7;
    if (wr_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got=%b need=1", wr_ready_o); end
    if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got=%b need=0", rd_valid_o); end
    if (rd_data_o !== 16'h0) begin miscompares++; $display("FAIL reset_rd_data got=%h need=0000", rd_data_o); end
    if (rd_last_o !== 1'b0) begin miscompares++; $display("FAIL reset_rd_last got=%b need=0", rd_last_o); end
    if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b need=0", ovf_o); end
    if (frame_cnt_o !== 3'd0) begin miscompares++; $display("FAIL reset_frame_cnt got=%0d need=0", frame_cnt_o); end
    if (drop_cnt_o !== 16'd0) begin miscompares++; $display("FAIL reset_drop_cnt got=%0d need=0", drop_cnt_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic();
    int w;
    got_d.delete(); got_l.delete();
    wr_beat(64'h0007_0006_0005_0004, 1'b0, 2'd0, 1'b0, w);
    wr_beat(64'h000B_000A_0009_0008, 1'b1, 2'd3, 1'b0, w);
    vectors++;
    if (frame_cnt_o !== 3'd1) begin miscompares++; $display("FAIL basic_frame_cnt_commit got=%0d need=1", frame_cnt_o); end
    wait_drain();
    vectors++;
    if (got_d.size() != 8) begin miscompares++; $display("FAIL basic_beats got=%0d need=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'(i + 4) || got_l[i] !== (i == 7))
        begin miscompares++; $display("FAIL basic_beat%0d got=%h/%b need=%h/%b", i, got_d[i], got_l[i], 16'(i + 4), i == 7); end
    end
    vectors++;
    if (frame_cnt_o !== 3'd0) begin miscompares++; $display("FAIL basic_frame_cnt_read got=%0d need=0", frame_cnt_o); end
  endtask

  task automatic test_partial();
    int w;
    got_d.delete(); got_l.delete();
    wr_beat(64'h0013_0012_0011_0010, 1'b0, 2'd0, 1'b0, w);
    wr_beat(64'h0017_0016_0015_0014, 1'b1, 2'd1, 1'b0, w);
    wait_drain();
    vectors++;
    if (got_d.size() != 6) begin miscompares++; $display("FAIL partial_beats got=%0d need=6", got_d.size()); end
    for (int i = 0; i < 6 && i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'(i + 16) || got_l[i] !== (i == 5))
        begin miscompares++; $display("FAIL partial_beat%0d got=%h/%b need=%h/%b", i, got_d[i], got_l[i], 16'(i + 16), i == 5); end
    end
  endtask

  task automatic test_overflow();
    int w;
    int w5;
    got_d.delete(); got_l.delete();
    ovf_seen = 0;
    for (int i = 0; i < 4; i++) wr_beat(64'hDEAD_0000_0000_0000 | 64'(i), 1'b0, 2'd0, 1'b0, w);
    wr_beat(64'hDEAD_0000_0000_0005, 1'b0, 2'd0, 1'b0, w5);
    wr_beat(64'hDEAD_0000_0000_0006, 1'b1, 2'd3, 1'b0, w);
    repeat (4) @(posedge clk_i);
    #1;
    vectors += 6;
    if (w5 != 1) begin miscompares++; $display("FAIL ovf_full_stall got=%0d need=1", w5); end
    if (w != 0) begin miscompares++; $display("FAIL ovf_discard_ready got_waits=%0d need=0", w); end
    if (ovf_seen != 1) begin miscompares++; $display("FAIL ovf_pulses got=%0d need=1", ovf_seen); end
    if (drop_cnt_o !== 16'd1) begin miscompares++; $display("FAIL ovf_drop_cnt got=%0d need=1", drop_cnt_o); end
    if (frame_cnt_o !== 3'd0) begin miscompares++; $display("FAIL ovf_frame_cnt got=%0d need=0", frame_cnt_o); end
    if (got_d.size() != 0) begin miscompares++; $display("FAIL ovf_leak got=%0d need=0", got_d.size()); end
    wr_beat(64'h0023_0022_0021_0020, 1'b0, 2'd0, 1'b0, w);
    wr_beat(64'h0027_0026_0025_0024, 1'b1, 2'd3, 1'b0, w);
    wait_drain();
    vectors++;
    if (got_d.size() != 8) begin miscompares++; $display("FAIL ovf_after_beats got=%0d need=8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'(i + 32) || got_l[i] !== (i == 7))
        begin miscompares++; $display("FAIL ovf_after_beat%0d got=%h/%b need=%h/%b", i, got_d[i], got_l[i], 16'(i + 32), i == 7); end
    end
  endtask

  task automatic test_drop();
    int w;
    got_d.delete(); got_l.delete();
    for (int i = 0; i < 3; i++) wr_beat(64'hBAD0_0000_0000_0000 | 64'(i), 1'b0, 2'd0, 1'b0, w);
    wr_beat(64'hBAD0_0000_0000_0003, 1'b1, 2'd3, 1'b1, w);
    wr_beat(64'h0033_0032_0031_0030, 1'b1, 2'd3, 1'b0, w);
    wait_drain();
    vectors += 2;
    if (drop_cnt_o !== 16'd2) begin miscompares++; $display("FAIL drop_cnt got=%0d need=2", drop_cnt_o); end
    if (got_d.size() != 4) begin miscompares++; $display("FAIL drop_beats got=%0d need=4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'(i + 48) || got_l[i] !== (i == 3))
        begin miscompares++; $display("FAIL drop_beat%0d got=%h/%b need=%h/%b", i, got_d[i], got_l[i], 16'(i + 48), i == 3); end
    end
  endtask

  task automatic test_back_to_back();
    int lens[8] = '{1, 2, 2, 1, 2, 1, 2, 2};
    int subs[8] = '{0, 3, 2, 3, 1, 1, 0, 3};
    logic [15:0] v = 16'h0100;
    int w;
    int n;
    logic last;
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
    ovf_seen = 0;
    rand_mode = 1;
    for (int f = 0; f < 8; f++) begin
      n = 0;
      while (frame_cnt_o > 3'd1 && n < 100) begin @(posedge clk_i); #1; n++; end
      for (int k = 0; k < lens[f]; k++) begin
        last = (k == lens[f] - 1);
        wr_beat({v + 16'd3, v + 16'd2, v + 16'd1, v}, last, last ? 2'(subs[f]) : 2'd0, 1'b0, w);
        for (int s = 0; s <= (last ? subs[f] : 3); s++) begin
          exp_d.push_back(v + 16'(s));
          exp_l.push_back(last && s == subs[f]);
        end
        v = v + 16'd4;
      end
    end
    wait_drain();
    rand_mode = 0;
    vectors += 4;
    if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL b2b_beats got=%0d need=%0d", got_d.size(), exp_d.size()); end
    if (ovf_seen != 0) begin miscompares++; $display("FAIL b2b_ovf got=%0d need=0", ovf_seen); end
    if (drop_cnt_o !== 16'd2) begin miscompares++; $display("FAIL b2b_drop_cnt got=%0d need=2", drop_cnt_o); end
    if (frame_cnt_o !== 3'd0) begin miscompares++; $display("FAIL b2b_frame_cnt got=%0d need=0", frame_cnt_o); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        begin miscompares++; $display("FAIL b2b_beat%0d got=%h/%b need=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_flush();
    int w;
    wr_beat(64'h00F3_00F2_00F1_00F0, 1'b0, 2'd0, 1'b0, w);
    wr_beat(64'h00F7_00F6_00F5_00F4, 1'b1, 2'd3, 1'b0, w);
    wait_rd_valid();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    vectors += 4;
    if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_rd_valid got=%b need=0", rd_valid_o); end
    if (frame_cnt_o !== 3'd0) begin miscompares++; $display("FAIL flush_frame_cnt got=%0d need=0", frame_cnt_o); end
    if (drop_cnt_o !== 16'd0) begin miscompares++; $display("FAIL flush_drop_cnt got=%0d need=0", drop_cnt_o); end
    if (wr_ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_wr_ready got=%b need=1", wr_ready_o); end
    got_d.delete(); got_l.delete();
    wr_beat(64'h0043_0042_0041_0040, 1'b1, 2'd3, 1'b0, w);
    wait_drain();
    vectors++;
    if (got_d.size() != 4) begin miscompares++; $display("FAIL flush_after_beats got=%0d need=4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'(i + 64) || got_l[i] !== (i == 3))
        begin miscompares++; $display("FAIL flush_after_beat%0d got=%h/%b need=%h/%b", i, got_d[i], got_l[i], 16'(i + 64), i == 3); end
    end
  endtask

  task automatic test_reset_midwrite();
    int w;
    wr_beat(64'h00E3_00E2_00E1_00E0, 1'b1, 2'd3, 1'b0, w);
    wr_beat(64'h00E7_00E6_00E5_00E4, 1'b0, 2'd0, 1'b0, w);
    wait_rd_valid();
    #2 rst_ni = 1'b0;
    #1;
    vectors += 3;
    if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_rd_valid got=%b need=0", rd_valid_o); end
    if (frame_cnt_o !== 3'd0) begin miscompares++; $display("FAIL rstmid_frame_cnt got=%0d need=0", frame_cnt_o); end
    if (wr_ready_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_wr_ready got=%b need=1", wr_ready_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    got_d.delete(); got_l.delete();
    @(posedge clk_i); #1;
    wr_beat(64'h0053_0052_0051_0050, 1'b1, 2'd3, 1'b0, w);
    wait_drain();
    vectors++;
    if (got_d.size() != 4) begin miscompares++; $display("FAIL rstmid_after_beats got=%0d need=4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== 16'(i + 80) || got_l[i] !== (i == 3))
        begin miscompares++; $display("FAIL rstmid_after_beat%0d got=%h/%b need=%h/%b", i, got_d[i], got_l[i], 16'(i + 80), i == 3); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_overflow();
    test_drop();
    test_back_to_back();
    test_flush();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
